// File: rtl/btc_nonce_sequencer.sv
// Nonce-range sequencer for the double-SHA-256 mining core.
// It issues one nonce per job and checks each returned hash against the target.
module btc_nonce_sequencer #(
  parameter int NONCE_W     = 32,
  parameter int HASH_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  input  logic [HASH_W-1:0]  target,
  input  logic               core_ready,
  output logic               core_start,
  output logic [NONCE_W-1:0] core_nonce,
  input  logic               core_done,
  input  logic [HASH_W-1:0]  hash_hi,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic               timeout_err,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [NONCE_W-1:0] attempts
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);
  // The timeout fires on the cycle the watchdog would step to TIMEOUT_CYC-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK
  } state_t;

  state_t state, state_next;

  logic [NONCE_W-1:0] cur_nonce;
  logic [NONCE_W-1:0] last_reg;
  logic [HASH_W-1:0]  target_reg;
  logic [HASH_W-1:0]  hash_reg;
  logic [WD_W-1:0]    watchdog;
  logic               hit;
  logic               at_last;
  logic               wd_expired;

  assign hit        = (hash_reg <= target_reg);
  assign at_last    = (cur_nonce == last_reg);
  assign wd_expired = (watchdog == WD_LAST);
  assign core_nonce = cur_nonce;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort overrides every other event, including the job launch itself.
  always_comb begin
    state_next = state;
    core_start = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state_next = ISSUE;
        end
        ISSUE: begin
          if (core_ready) begin
            core_start = 1'b1;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (core_done)       state_next = CHECK;
          else if (wd_expired) state_next = IDLE;
        end
        CHECK: begin
          if (hit || at_last) state_next = IDLE;
          else                state_next = ISSUE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cur_nonce   <= '0;
      last_reg    <= '0;
      target_reg  <= '0;
      hash_reg    <= '0;
      watchdog    <= '0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
      found_nonce <= '0;
      attempts    <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cur_nonce   <= nonce_first;
            last_reg    <= nonce_last;
            target_reg  <= target;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
            attempts    <= '0;
            found_nonce <= '0;
            busy        <= 1'b1;
          end
        end
        ISSUE: begin
          if (core_ready) watchdog <= '0;
        end
        WAIT: begin
          if (core_done) begin
            hash_reg <= hash_hi;
            if (attempts != '1) attempts <= attempts + NONCE_W'(1);
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        CHECK: begin
          // A hit on the final nonce reports found rather than exhausted.
          if (hit) begin
            found       <= 1'b1;
            found_nonce <= cur_nonce;
            busy        <= 1'b0;
          end else if (at_last) begin
            exhausted <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cur_nonce <= cur_nonce + NONCE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btc_nonce_sequencer.sv
// Scoreboard bench for btc_nonce_sequencer with a 3-cycle behavioural mining core.
module tb_btc_nonce_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] nonce_first;
  logic [31:0] nonce_last;
  logic [31:0] target;
  logic        core_ready;
  logic        core_start;
  logic [31:0] core_nonce;
  logic        core_done;
  logic [31:0] hash_hi;
  logic        busy;
  logic        found;
  logic        exhausted;
  logic        timeout_err;
  logic [31:0] found_nonce;
  logic [31:0] attempts;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          cyc          = 0;
  int          start_cyc    = 0;
  int          launches     = 0;
  int          pend_cnt     = 0;
  logic [31:0] pend_nonce   = '0;
  logic [31:0] exp_n        = '0;
  bit          core_respond = 1'b1;
  bit          hit_en       = 1'b0;
  logic [31:0] hit_nonce    = '0;
  logic [31:0] hit_hash     = '0;
  int          launch_cyc[$];
  logic [31:0] exp_nonce[$];

  btc_nonce_sequencer #(
    .NONCE_W    (32),
    .HASH_W     (32),
    .TIMEOUT_CYC(16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start      (start),
    .abort      (abort),
    .nonce_first(nonce_first),
    .nonce_last (nonce_last),
    .target     (target),
    .core_ready (core_ready),
    .core_start (core_start),
    .core_nonce (core_nonce),
    .core_done  (core_done),
    .hash_hi    (hash_hi),
    .busy       (busy),
    .found      (found),
    .exhausted  (exhausted),
    .timeout_err(timeout_err),
    .found_nonce(found_nonce),
    .attempts   (attempts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Core model and launch scoreboard: samples just after the falling edge,
  // answers 3 cycles after a launch; every launch pops one expected nonce.
  always begin
    @(negedge clk);
    #1;
    core_done = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        core_done = 1'b1;
        hash_hi   = (hit_en && pend_nonce == hit_nonce) ? hit_hash : 32'hFFFF_FFFF;
      end
    end
    if (core_start) begin
      launches++;
      launch_cyc.push_back(cyc);
      n_compared++;
      if (exp_nonce.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL launch_unexpected: core_nonce=%h, required no launch", core_nonce);
      end else begin
        exp_n = exp_nonce.pop_front();
        if (core_nonce !== exp_n) begin
          n_mismatched++;
          $display("[TB] FAIL launch_nonce: got %h, want %h", core_nonce, exp_n);
        end
      end
      pend_nonce = core_nonce;
      pend_cnt   = core_respond ? 3 : 0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "[TB] global time limit");
  end

  task automatic pulse_start(input logic [31:0] f, input logic [31:0] l, input logic [31:0] t);
    @(negedge clk);
    nonce_first = f;
    nonce_last  = l;
    target      = t;
    start       = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
    n_compared++; if (found !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_found: got %b, want 0", found); end
    n_compared++; if (exhausted !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_exhausted: got %b, want 0", exhausted); end
    n_compared++; if (timeout_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_timeout: got %b, want 0", timeout_err); end
    n_compared++; if (found_nonce !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_found_nonce: got %h, want 0", found_nonce); end
    n_compared++; if (attempts !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_attempts: got %h, want 0", attempts); end
    n_compared++; if (core_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_core_start: got %b, want 0", core_start); end
    n_compared++; if (core_nonce !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_core_nonce: got %h, want 0", core_nonce); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hit();
    bit ok;
    hit_en = 1'b1; hit_nonce = 32'h105; hit_hash = 32'h0000_1234;
    core_respond = 1'b1; core_ready = 1'b1;
    launch_cyc.delete();
    for (int n = 32'h100; n <= 32'h105; n++) exp_nonce.push_back(32'(n));
    pulse_start(32'h100, 32'h1FF, 32'h0000_FFFF);
    wait_idle(200, ok);
    n_compared++; if (!ok) begin n_mismatched++; $display("[TB] FAIL hit_busy_fall: busy=%b after 200 cycles, want 0", busy); end
    n_compared++; if (found !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hit_found: got %b, want 1", found); end
    n_compared++; if (found_nonce !== 32'h105) begin n_mismatched++; $display("[TB] FAIL hit_found_nonce: got %h, want 105", found_nonce); end
    n_compared++; if (attempts !== 32'd6) begin n_mismatched++; $display("[TB] FAIL hit_attempts: got %0d, want 6", attempts); end
    n_compared++; if (exhausted !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hit_exhausted: got %b, want 0", exhausted); end
    n_compared++; if (exp_nonce.size() != 0) begin n_mismatched++; $display("[TB] FAIL hit_launch_count: %0d nonces never launched, want 0", exp_nonce.size()); end
    n_compared++;
    if (launch_cyc.size() == 0 || launch_cyc[0] - start_cyc != 1) begin
      n_mismatched++;
      $display("[TB] FAIL hit_start_latency: launches=%0d first delta=%0d, want delta 1", launch_cyc.size(),
               (launch_cyc.size() == 0) ? -1 : launch_cyc[0] - start_cyc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_hit_last();
    bit ok;
    hit_en = 1'b1; hit_nonce = 32'h42; hit_hash = 32'h0000_0010;
    exp_nonce.push_back(32'h42);
    pulse_start(32'h42, 32'h42, 32'h0000_FFFF);
    wait_idle(50, ok);
    n_compared++; if (!ok) begin n_mismatched++; $display("[TB] FAIL last_busy_fall: busy=%b, want 0", busy); end
    n_compared++; if (found !== 1'b1) begin n_mismatched++; $display("[TB] FAIL last_found: got %b, want 1", found); end
    n_compared++; if (exhausted !== 1'b0) begin n_mismatched++; $display("[TB] FAIL last_exhausted: got %b, want 0", exhausted); end
    n_compared++; if (attempts !== 32'd1) begin n_mismatched++; $display("[TB] FAIL last_attempts: got %0d, want 1", attempts); end
    n_compared++; if (found_nonce !== 32'h42) begin n_mismatched++; $display("[TB] FAIL last_found_nonce: got %h, want 42", found_nonce); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap_exhaust();
    bit ok;
    hit_en = 1'b0;
    exp_nonce.push_back(32'hFFFF_FFFE);
    exp_nonce.push_back(32'hFFFF_FFFF);
    exp_nonce.push_back(32'h0000_0000);
    exp_nonce.push_back(32'h0000_0001);
    pulse_start(32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_FFFF);
    wait_idle(100, ok);
    n_compared++; if (!ok) begin n_mismatched++; $display("[TB] FAIL wrap_busy_fall: busy=%b, want 0", busy); end
    n_compared++; if (exhausted !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_exhausted: got %b, want 1", exhausted); end
    n_compared++; if (attempts !== 32'd4) begin n_mismatched++; $display("[TB] FAIL wrap_attempts: got %0d, want 4", attempts); end
    n_compared++; if (found !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wrap_found: got %b, want 0", found); end
    n_compared++; if (exp_nonce.size() != 0) begin n_mismatched++; $display("[TB] FAIL wrap_launch_count: %0d nonces never launched, want 0", exp_nonce.size()); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_pressure();
    bit ok;
    int n0;
    hit_en = 1'b0;
    core_ready = 1'b0;
    launch_cyc.delete();
    n0 = launches;
    exp_nonce.push_back(32'h10);
    exp_nonce.push_back(32'h11);
    exp_nonce.push_back(32'h12);
    pulse_start(32'h10, 32'h12, 32'h0);
    repeat (50) @(negedge clk);
    n_compared++; if (launches != n0) begin n_mismatched++; $display("[TB] FAIL bp_no_launch: got %0d launches, want 0", launches - n0); end
    n_compared++; if (timeout_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_timeout: got %b, want 0", timeout_err); end
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_busy: got %b, want 1", busy); end
    core_ready = 1'b1;
    wait_idle(100, ok);
    n_compared++; if (!ok) begin n_mismatched++; $display("[TB] FAIL bp_busy_fall: busy=%b, want 0", busy); end
    n_compared++;
    if (launch_cyc.size() != 3) begin
      n_mismatched++;
      $display("[TB] FAIL bp_launches: got %0d, want 3", launch_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_compared++;
        if (launch_cyc[i] - launch_cyc[i-1] != 5) begin
          n_mismatched++;
          $display("[TB] FAIL bp_spacing: got %0d cycles, want 5", launch_cyc[i] - launch_cyc[i-1]);
        end
      end
    end
    n_compared++; if (exhausted !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_exhausted: got %b, want 1", exhausted); end
    n_compared++; if (attempts !== 32'd3) begin n_mismatched++; $display("[TB] FAIL bp_attempts: got %0d, want 3", attempts); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int t_cyc;
    hit_en = 1'b0;
    core_respond = 1'b0;
    launch_cyc.delete();
    exp_nonce.push_back(32'h200);
    pulse_start(32'h200, 32'h2FF, 32'h0);
    ok = 1'b0;
    t_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        ok = 1'b1;
        t_cyc = cyc;
        break;
      end
    end
    n_compared++; if (!ok) begin n_mismatched++; $display("[TB] FAIL to_flag: timeout_err=%b after 100 cycles, want 1", timeout_err); end
    n_compared++;
    if (launch_cyc.size() != 1 || t_cyc - launch_cyc[0] != 16) begin
      n_mismatched++;
      $display("[TB] FAIL to_delay: launches=%0d delay=%0d, want 1 launch and 16 cycles", launch_cyc.size(),
               (launch_cyc.size() == 0) ? -1 : t_cyc - launch_cyc[0]);
    end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL to_busy: got %b, want 0", busy); end
    repeat (3) @(negedge clk);
    core_respond = 1'b1;
    exp_nonce.push_back(32'h300);
    pulse_start(32'h300, 32'h300, 32'hFFFF_FFFF);
    n_compared++; if (timeout_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL to_cleared: got %b, want 0", timeout_err); end
    wait_idle(50, ok);
    n_compared++; if (found !== 1'b1 || found_nonce !== 32'h300) begin n_mismatched++; $display("[TB] FAIL to_restart_found: got %b/%h, want 1/300", found, found_nonce); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort_priority();
    bit got;
    int n0;
    hit_en = 1'b1; hit_nonce = 32'h500; hit_hash = 32'h0;
    core_respond = 1'b1; core_ready = 1'b1;
    exp_nonce.push_back(32'h500);
    n0 = launches;
    pulse_start(32'h500, 32'h5FF, 32'h0000_FFFF);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (launches != n0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_compared++; if (!got) begin n_mismatched++; $display("[TB] FAIL ab_launch: no launch within 20 cycles, want 1"); end
    @(negedge clk);
    nonce_first = 32'h900;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nonce_first = 32'h0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_compared++; if (found !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ab_found: got %b, want 0", found); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ab_busy: got %b, want 0", busy); end
    n_compared++; if (attempts !== 32'd0) begin n_mismatched++; $display("[TB] FAIL ab_attempts: got %0d, want 0", attempts); end
    n_compared++; if (core_nonce !== 32'h500) begin n_mismatched++; $display("[TB] FAIL ab_no_relatch: got %h, want 500", core_nonce); end
    repeat (10) @(negedge clk);
    n_compared++; if (launches != n0 + 1) begin n_mismatched++; $display("[TB] FAIL ab_idle: got %0d launches, want 1", launches - n0); end
    n_compared++; if (found !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ab_late_result: found=%b, want 0", found); end
  endtask

  task automatic test_abort_mid();
    bit ok;
    hit_en = 1'b0;
    exp_nonce.push_back(32'h600);
    exp_nonce.push_back(32'h601);
    pulse_start(32'h600, 32'h6FF, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (attempts === 32'd2) begin
        ok = 1'b1;
        break;
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_compared++; if (!ok) begin n_mismatched++; $display("[TB] FAIL abm_progress: attempts=%0d, want 2", attempts); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abm_busy: got %b, want 0", busy); end
    n_compared++; if (attempts !== 32'd2) begin n_mismatched++; $display("[TB] FAIL abm_attempts_hold: got %0d, want 2", attempts); end
    n_compared++; if (exhausted !== 1'b0 || found !== 1'b0 || timeout_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abm_flags: got %b%b%b, want 000", found, exhausted, timeout_err); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit got;
    int n0;
    hit_en = 1'b0;
    exp_nonce.push_back(32'h700);
    exp_nonce.push_back(32'h701);
    n0 = launches;
    pulse_start(32'h700, 32'h7FF, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (launches >= n0 + 2) begin
        got = 1'b1;
        break;
      end
    end
    n_compared++; if (!got) begin n_mismatched++; $display("[TB] FAIL rst_launches: got %0d, want 2", launches - n0); end
    @(negedge clk);
    #2;
    n_compared++; if (busy !== 1'b1 || attempts !== 32'd1) begin n_mismatched++; $display("[TB] FAIL rst_pre_state: busy=%b attempts=%0d, want 1/1", busy, attempts); end
    rst = 1'b1;
    #1;
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_busy: got %b, want 0", busy); end
    n_compared++; if (found !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_found: got %b, want 0", found); end
    n_compared++; if (attempts !== 32'd0) begin n_mismatched++; $display("[TB] FAIL rst_attempts: got %0d, want 0", attempts); end
    n_compared++; if (core_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_core_start: got %b, want 0", core_start); end
    n_compared++; if (core_nonce !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_core_nonce: got %h, want 0", core_nonce); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    nonce_first = '0; nonce_last = '0; target = '0;
    core_ready = 1'b1; core_done = 1'b0; hash_hi = '0;
    $display("[TB] btc_nonce_sequencer bench starting");
    test_reset();
    test_hit();
    test_single_hit_last();
    test_wrap_exhaust();
    test_back_pressure();
    test_timeout();
    test_abort_priority();
    test_abort_mid();
    test_async_reset();
    n_compared++;
    if (exp_nonce.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL sb_drain: %0d expected launches left, want 0", exp_nonce.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/btc_nonce_sequencer.md
Name: btc_nonce_sequencer

Overview:
- Controller that sequences the double-SHA-256 mining core across a nonce range inside the Caravel user project.
- Firmware programs a start nonce, end nonce and target over the user-project register interface, then pulses start.
- The block issues one nonce per core job and compares the top bits of each returned hash against the target.
- It stops on a hit, when the range is exhausted, on a core timeout, or on abort. Status feeds the register file and the GPIO check bits.

Parameters:
- NONCE_W, 32, nonce and attempt-counter width.
- HASH_W, 32, number of most-significant hash bits returned by the core and compared to the target.
- TIMEOUT_CYC, 1024, maximum cycles to wait for core_done before flagging an error; must be >= 2.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a search; ignored while busy
- abort  in  1  level or pulse that terminates the search
- nonce_first  in  NONCE_W  first nonce, sampled on accepted start
- nonce_last  in  NONCE_W  last nonce (inclusive), sampled on accepted start
- target  in  HASH_W  hit threshold, sampled on accepted start
- core_ready  in  1  core can accept a job
- core_start  out  1  one-cycle job launch to the core
- core_nonce  out  NONCE_W  nonce for the job; stable from core_start until the next launch
- core_done  in  1  one-cycle pulse: hash_hi is valid
- hash_hi  in  HASH_W  MSBs of the final hash, big-endian significance
- busy  out  1  search in progress
- found  out  1  sticky hit flag
- exhausted  out  1  sticky range-complete flag
- timeout_err  out  1  sticky core-timeout flag
- found_nonce  out  NONCE_W  nonce that produced the hit
- attempts  out  NONCE_W  completed core jobs in the current search, saturating

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0; cur_nonce 0; watchdog 0.
- State machine: IDLE, ISSUE, WAIT, CHECK.
- IDLE:
  - start=1 and abort=0: latch nonce_first into cur_nonce, latch nonce_last and target.
  - Same edge: clear found, exhausted, timeout_err, attempts and found_nonce; set busy=1; go to ISSUE.
- ISSUE:
  - core_start = (state==ISSUE) & core_ready, combinational; core_nonce = cur_nonce, registered.
  - core_ready=1: go to WAIT and clear the watchdog.
  - core_ready=0: stay in ISSUE; the watchdog does not count.
- WAIT:
  - core_done=1: register hash_hi, go to CHECK, increment attempts (saturating at all-ones).
  - Otherwise the watchdog increments each cycle. When it reaches TIMEOUT_CYC-1 with no core_done: set timeout_err=1, busy=0, go to IDLE.
  - core_done and the timeout firing in the same cycle: core_done wins.
  - core_done seen outside WAIT is ignored.
- CHECK (one cycle):
  - hash_reg <= target, unsigned: found=1, found_nonce=cur_nonce, busy=0, go to IDLE.
  - Else if cur_nonce == nonce_last: exhausted=1, busy=0, go to IDLE.
  - Else: cur_nonce = cur_nonce + 1 mod 2^NONCE_W, go to ISSUE.
  - Wrap-around is legal: nonce_last < nonce_first searches through all-ones and 0.
  - nonce_first == nonce_last gives exactly one job.
  - A hit on the last nonce reports found, not exhausted.
- Throughput: with core_ready held at 1, core_done at cycle k produces the next core_start at cycle k+2.
- Latency: start at cycle 0 produces core_start at cycle 1.
- abort:
  - Any state: the next state is IDLE and busy=0. No flag is set, and found_nonce and attempts hold their values.
  - core_start is forced to 0 in the abort cycle.
  - Abort wins over start, core_done and timeout in the same cycle.
  - An in-flight core result that arrives after abort is ignored.
- Mid-operation reset: wb_rst_i returns every register to its reset value immediately, regardless of state.

Test Plan:
- Hit: nonce_first=0x100, nonce_last=0x1FF, target=0x0000FFFF. Model returns hash_hi=0xFFFFFFFF except nonce 0x105, which returns 0x00001234. Required: found=1, found_nonce=0x105, attempts=6, exhausted=0, busy falls.
- Exhaust with wrap: nonce_first=0xFFFFFFFE, nonce_last=0x00000001, no hits. Required: core_nonce sequence FFFFFFFE, FFFFFFFF, 0, 1; then exhausted=1, attempts=4, found=0.
- Back-pressure and throughput: hold core_ready=0 for 50 cycles after start. Required: no core_start and no timeout_err during the hold. Then core_ready=1 with a 3-cycle core: core_start spacing is 5 cycles.
- Timeout: TIMEOUT_CYC=16, core never asserts core_done. Required: timeout_err=1 and busy=0 exactly 16 cycles after core_start; a new start then clears timeout_err.
- Abort priority: assert abort in the same cycle as core_done carrying a hit. Required: found=0, busy=0 next cycle, state IDLE. A start pulse during busy is ignored and does not relatch nonce_first.
- Async reset: assert wb_rst_i mid-WAIT between clock edges. Required: busy, found, attempts and core_start all 0 before the next edge.
